object_visibility_sequencer: RTL

//  Per-object visibility controller in front of the priority object mux in the VGA path.

---
 rtl/object_visibility_sequencer_if.sv | 21 ++
 rtl/object_visibility_sequencer.sv | 94 +++++++++
 2 files changed

// File: rtl/object_visibility_sequencer_if.sv
// object_visibility_sequencer_if: command handshake, frame strobe and draw-request bundle for the visibility sequencer.
interface object_visibility_sequencer_if #(
   parameter int N  = 8,
   parameter int FW = 6,
   parameter int IW = $clog2(N + 1)  // one spare code so an out-of-range index can be expressed
);
   logic          startOfFrame;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [IW-1:0] cmd_index;
   logic [FW-1:0] cmd_frames;
   logic          cmd_error;
   logic [0:N-1]  raw_draw_requests;
   logic [0:N-1]  draw_requests;
   logic [0:N-1]  visible_mask;
   modport master(output startOfFrame, cmd_valid, cmd_op, cmd_index, cmd_frames, raw_draw_requests,
                  input cmd_ready, cmd_error, draw_requests, visible_mask);
   modport slave(input startOfFrame, cmd_valid, cmd_op, cmd_index, cmd_frames, raw_draw_requests,
                 output cmd_ready, cmd_error, draw_requests, visible_mask);
endinterface

// File: rtl/object_visibility_sequencer.sv
// object_visibility_sequencer: frame-synchronous show/hide/blink control and draw-request gating per object.
module object_visibility_sequencer #(
   parameter int NUMBER_OF_OBJECTS = 8,
   parameter int BLINK_HALF_PERIOD = 8,
   parameter int FRAMES_WIDTH      = 6
) (
   input logic clk,
   input logic reset,
   object_visibility_sequencer_if.slave bus
);
   localparam int N  = NUMBER_OF_OBJECTS;
   localparam int IW = $clog2(N + 1);
   localparam int CW = BLINK_HALF_PERIOD > 1 ? $clog2(BLINK_HALF_PERIOD) : 1;
   localparam logic [1:0] SHOW = 2'b00, BT = 2'b10;
   typedef enum logic {IDLE, PENDING} state_t;
   state_t state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [FRAMES_WIDTH-1:0] frames_q, frames_d;
   logic err_q, err_d, phase_q, phase_d, accept, wrap;
   logic [CW-1:0] bc_q, bc_d;
   logic [N-1:0][1:0] mode_q, mode_d;
   logic [N-1:0][FRAMES_WIDTH-1:0] cnt_q, cnt_d;
   logic [0:N-1] vis_q, vis_d;

   always_comb begin
      accept   = bus.cmd_valid && state_q == IDLE;
      wrap     = bc_q == CW'(BLINK_HALF_PERIOD - 1);
      state_d  = state_q;
      op_d     = op_q;
      idx_d    = idx_q;
      frames_d = frames_q;
      err_d    = accept && bus.cmd_index >= IW'(N);
      bc_d     = bus.startOfFrame ? (wrap ? '0 : bc_q + 1'b1) : bc_q;
      phase_d  = phase_q ^ (bus.startOfFrame && wrap);
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      if (accept && !err_d) begin
         state_d  = PENDING;
         op_d     = bus.cmd_op;
         idx_d    = bus.cmd_index;
         frames_d = bus.cmd_frames;
      end
      if (bus.startOfFrame) begin
         for (int i = 0; i < N; i++)
            if (mode_q[i] == BT) begin
               mode_d[i] = cnt_q[i] > FRAMES_WIDTH'(1) ? BT : SHOW;
               cnt_d[i]  = cnt_q[i] > FRAMES_WIDTH'(1) ? cnt_q[i] - 1'b1 : '0;
            end
         // the staged command lands after the tick so it wins for its own object
         if (state_q == PENDING) begin
            state_d = IDLE;
            for (int i = 0; i < N; i++)
               if (idx_q == IW'(i)) begin
                  mode_d[i] = (op_q == BT && frames_q == '0) ? SHOW : op_q;
                  cnt_d[i]  = op_q == BT ? frames_q : '0;
               end
         end
      end
      for (int i = 0; i < N; i++)
         vis_d[i] = mode_d[i] == SHOW || (mode_d[i][1] && !phase_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         idx_q    <= '0;
         frames_q <= '0;
         err_q    <= 1'b0;
         bc_q     <= '0;
         phase_q  <= 1'b0;
         mode_q   <= '0;
         cnt_q    <= '0;
         vis_q    <= '1;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         idx_q    <= idx_d;
         frames_q <= frames_d;
         err_q    <= err_d;
         bc_q     <= bc_d;
         phase_q  <= phase_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         vis_q    <= vis_d;
      end
   end

   assign bus.cmd_ready     = state_q == IDLE;
   assign bus.cmd_error     = err_q;
   assign bus.visible_mask  = vis_q;
   assign bus.draw_requests = bus.raw_draw_requests & vis_q;
endmodule
